run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
Synthesizable run controller for the 5-stage RISC-V core, replacing the fixed reset-then-run-forever bring-up with a parametrised, sequenced one. It holds the core in reset for a programmable number of cycles, then runs it with a clock enable. It stops on halt detection, an external stop request or a cycle timeout, and keeps a cycle counter plus NUM_EVT saturating event counters (retire, stall, ...). It sits beside `top` and drives its active-high core reset and clock enable.

Parameters:
RST_HOLD_CYCLES, 4, cycles core_rst stays high in HOLD (>=1)
TIMEOUT_CYCLES, 50000, max RUN cycles; 0 disables timeout
CNT_W, 32, width of cycle and event counters
NUM_EVT, 2, number of event counter channels (>=1)
STALL_LIMIT, 1024, evt[0]-idle cycles before hang (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
stop_req  in  1  level; request stop while in RUN
halt_det  in  1  core halt indication (ecall/self-loop), sampled in RUN
evt  in  NUM_EVT  per-cycle event strobes; evt[0] = instruction retired
core_rst  out  1  active-high reset to core
core_en  out  1  core clock enable
busy  out  1  high in HOLD or RUN
done  out  1  high in DONE
cause  out  3  stop cause: 0 none, 1 halt, 2 stop_req, 3 timeout, 4 hang
cycle_cnt  out  CNT_W  RUN cycles of the current/last run
evt_cnt  out  NUM_EVT*CNT_W  flattened event counts; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (reset=0, async): state=IDLE; core_rst=1, core_en=0, busy=0, done=0, cause=0, all counters 0.
- States: IDLE, HOLD, RUN, DONE. Outputs are decoded from registered state:
  - IDLE: core_rst=1, core_en=0.
  - HOLD: core_rst=1, core_en=0.
  - RUN: core_rst=0, core_en=1.
  - DONE: core_rst=0, core_en=0 (core frozen for inspection).
- IDLE/DONE + start -> HOLD. The same edge clears cycle_cnt, evt_cnt and cause. start is ignored in HOLD and RUN.
- HOLD: hold counter loads RST_HOLD_CYCLES-1 on entry and decrements. At 0 -> RUN. Result: exactly RST_HOLD_CYCLES cycles in HOLD.
- RUN, each cycle:
  - cycle_cnt += 1.
  - evt_cnt[i] += 1 when evt[i]=1.
  - All counters saturate at 2^CNT_W-1 and never wrap.
  - Inputs are sampled in the same cycle, and that cycle is counted.
- RUN stop conditions, evaluated each cycle, priority halt_det > stop_req > timeout:
  - halt_det=1 -> DONE, cause=1.
  - stop_req=1 -> DONE, cause=2.
  - TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1 -> DONE, cause=3. Result: cycle_cnt==TIMEOUT_CYCLES in DONE.
- done, cause and frozen counters are visible the cycle after the stop condition. They persist until the next start or reset.
- Simultaneous start with anything in DONE: start wins.
- stop_req or halt_det outside RUN: ignored.
- reset assertion mid-HOLD or mid-RUN: immediate return to IDLE with everything cleared. No partial counts are retained.
- Counter arithmetic is unsigned, CNT_W bits. Comparisons against parameters use CNT_W-wide constants; parameters must fit in CNT_W (elaboration assertion).

Optional Feature:
Macro RUN_CTRL_HANG_DETECT_EN.
- Defined:
  - A stall counter of width $clog2(STALL_LIMIT+1) clears on RUN entry and on any evt[0]=1 cycle, and increments otherwise.
  - When it reaches STALL_LIMIT in RUN -> DONE, cause=4.
  - Lowest priority, below timeout.
- Undefined: no stall counter; cause value 4 never produced.

Decomposition:
- Package run_ctrl_pkg holds:
  - state_e enum {IDLE, HOLD, RUN, DONE}.
  - cause_e enum (3-bit) {CAUSE_NONE, CAUSE_HALT, CAUSE_STOP, CAUSE_TIMEOUT, CAUSE_HANG}.
- Sub-module sat_counter #(W): clr, inc, q, saturating at all-ones. It is instantiated for cycle_cnt and, via generate, for each evt channel.

Test Plan:
- Reset release, start pulse, RST_HOLD_CYCLES=4 -> core_rst high exactly 4 cycles after start, then core_en=1, busy=1.
- Run with evt[0] every cycle, halt_det pulsed on the 10th RUN cycle -> done=1 next cycle, cause=1, cycle_cnt=10, evt_cnt[0]=10.
- TIMEOUT_CYCLES=50, no halt -> cause=3, cycle_cnt=50.
- halt_det and stop_req in the same cycle -> cause=1.
- CNT_W=4, run 20 cycles with evt[1]=1, then stop_req -> cycle_cnt=15, evt_cnt[1]=15 (saturated).
- reset=0 mid-RUN, then restart -> counters 0, state IDLE.
- RUN_CTRL_HANG_DETECT_EN, STALL_LIMIT=8, evt[0] never set -> cause=4 after 8 RUN cycles.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM states and stop-cause codes.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_HALT    = 3'd1,
        CAUSE_STOP    = 3'd2,
        CAUSE_TIMEOUT = 3'd3,
        CAUSE_HANG    = 3'd4
    } cause_e;

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q != '1)) begin
            q_d = q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Core bring-up sequencer: reset hold, run with clock enable, stop and count.
// Define RUN_CTRL_HANG_DETECT_EN to stop the run when evt[0] stays idle for STALL_LIMIT cycles.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 50000,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned NUM_EVT         = 2,
    parameter int unsigned STALL_LIMIT     = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop_req,
    input  logic                     halt_det,
    input  logic [NUM_EVT-1:0]       evt,
    output logic                     core_rst,
    output logic                     core_en,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               cause,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [NUM_EVT*CNT_W-1:0] evt_cnt
);

    localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT    = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("RST_HOLD_CYCLES must be at least 1");
    end
    if (NUM_EVT < 1) begin : g_bad_evt
        $error("NUM_EVT must be at least 1");
    end
    if (STALL_LIMIT < 1) begin : g_bad_stall
        $error("STALL_LIMIT must be at least 1");
    end
    if ((64'(TIMEOUT_CYCLES) >> CNT_W) != 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES does not fit in CNT_W bits");
    end

    state_e              state_q, state_d;
    cause_e              cause_q, cause_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                cnt_clr;
    logic                run;
    logic                timeout;
    logic                hang;

    assign run     = (state_q == RUN);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cycle_cnt == TIMEOUT_LAST);

`ifdef RUN_CTRL_HANG_DETECT_EN
    localparam int unsigned        STALL_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic [STALL_W-1:0] stall_inc;

    // Held at zero outside RUN, so every run starts with a fresh count.
    assign stall_inc = stall_q + STALL_W'(1);
    assign stall_d   = (!run || evt[0]) ? '0 : stall_inc;
    assign hang      = run && !evt[0] && (stall_inc == STALL_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign hang = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = HOLD;
                    hold_d  = HOLD_INIT;
                    cause_d = CAUSE_NONE;
                    cnt_clr = 1'b1;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            RUN: begin
                if (halt_det) begin
                    state_d = DONE;
                    cause_d = CAUSE_HALT;
                end else if (stop_req) begin
                    state_d = DONE;
                    cause_d = CAUSE_STOP;
                end else if (timeout) begin
                    state_d = DONE;
                    cause_d = CAUSE_TIMEOUT;
                end else if (hang) begin
                    state_d = DONE;
                    cause_d = CAUSE_HANG;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_rst = (state_q == IDLE) || (state_q == HOLD);
    assign core_en  = run;
    assign busy     = (state_q == HOLD) || run;
    assign done     = (state_q == DONE);
    assign cause    = cause_q;

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (run),
        .q    (cycle_cnt)
    );

    for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
        sat_counter #(
            .W(CNT_W)
        ) u_evt_cnt (
            .clk  (clk),
            .reset(reset),
            .clr  (cnt_clr),
            .inc  (run && evt[i]),
            .q    (evt_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: one 32-bit instance (a) and one 4-bit saturating instance (b).
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          vec = 0;
    int          errs = 0;

    logic        a_start = 0, a_stop_req = 0, a_halt_det = 0;
    logic [1:0]  a_evt = '0;
    logic        a_core_rst, a_core_en, a_busy, a_done;
    logic [2:0]  a_cause;
    logic [31:0] a_cycle_cnt;
    logic [63:0] a_evt_cnt;

    logic        b_start = 0, b_stop_req = 0, b_halt_det = 0;
    logic [1:0]  b_evt = '0;
    logic        b_core_rst, b_core_en, b_busy, b_done;
    logic [2:0]  b_cause;
    logic [3:0]  b_cycle_cnt;
    logic [7:0]  b_evt_cnt;

    always #5 clk = ~clk;

    run_ctrl #(
        .RST_HOLD_CYCLES(4), .TIMEOUT_CYCLES(50), .CNT_W(32), .NUM_EVT(2), .STALL_LIMIT(8)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .stop_req(a_stop_req),
        .halt_det(a_halt_det), .evt(a_evt), .core_rst(a_core_rst), .core_en(a_core_en),
        .busy(a_busy), .done(a_done), .cause(a_cause), .cycle_cnt(a_cycle_cnt),
        .evt_cnt(a_evt_cnt)
    );

    run_ctrl #(
        .RST_HOLD_CYCLES(2), .TIMEOUT_CYCLES(0), .CNT_W(4), .NUM_EVT(2), .STALL_LIMIT(1024)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .stop_req(b_stop_req),
        .halt_det(b_halt_det), .evt(b_evt), .core_rst(b_core_rst), .core_en(b_core_en),
        .busy(b_busy), .done(b_done), .cause(b_cause), .cycle_cnt(b_cycle_cnt),
        .evt_cnt(b_evt_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then step through HOLD; n is the number of cycles core_rst was seen high.
    task automatic a_start_run(output int n);
        a_start = 1;
        tick();
        a_start = 0;
        n = 0;
        while (a_core_rst && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic b_start_run(output int n);
        b_start = 1;
        tick();
        b_start = 0;
        n = 0;
        while (b_core_rst && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 0;
        #3;
        vec++; if (a_core_rst !== 1'b1) begin errs++; $display("FAIL reset_core_rst: got %b want 1", a_core_rst); end
        vec++; if (a_core_en !== 1'b0) begin errs++; $display("FAIL reset_core_en: got %b want 0", a_core_en); end
        vec++; if ({a_busy, a_done} !== 2'b00) begin errs++; $display("FAIL reset_busy_done: got %b want 00", {a_busy, a_done}); end
        vec++; if (a_cause !== 3'd0) begin errs++; $display("FAIL reset_cause: got %0d want 0", a_cause); end
        vec++; if (a_cycle_cnt !== 32'd0 || a_evt_cnt !== 64'd0) begin errs++; $display("FAIL reset_counters: got %0d/%0h want 0/0", a_cycle_cnt, a_evt_cnt); end
        vec++; if (b_core_rst !== 1'b1 || b_cycle_cnt !== 4'd0) begin errs++; $display("FAIL reset_b: got rst=%b cnt=%0d want 1/0", b_core_rst, b_cycle_cnt); end
        tick();
        tick();
        reset = 1;
        tick();
        vec++; if (a_core_rst !== 1'b1 || a_busy !== 1'b0) begin errs++; $display("FAIL idle_after_reset: got rst=%b busy=%b want 1/0", a_core_rst, a_busy); end
    endtask

    task automatic test_hold();
        int n;
        a_start = 1;
        tick();
        a_start = 0;
        vec++; if (a_busy !== 1'b1 || a_core_en !== 1'b0) begin errs++; $display("FAIL hold_entry: got busy=%b en=%b want 1/0", a_busy, a_core_en); end
        n = 0;
        while (a_core_rst && n < 20) begin
            n++;
            tick();
        end
        vec++; if (n !== 4) begin errs++; $display("FAIL hold_length: got %0d cycles want 4", n); end
        vec++; if (a_core_en !== 1'b1 || a_busy !== 1'b1) begin errs++; $display("FAIL run_entry: got en=%b busy=%b want 1/1", a_core_en, a_busy); end
        vec++; if (a_cycle_cnt !== 32'd0) begin errs++; $display("FAIL run_entry_cnt: got %0d want 0", a_cycle_cnt); end
    endtask

    // Continues from the first RUN cycle left by test_hold.
    task automatic test_halt();
        a_evt = 2'b01;
        repeat (9) tick();
        a_halt_det = 1;
        tick();
        a_halt_det = 0;
        a_evt = 2'b00;
        vec++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin errs++; $display("FAIL halt_done: got done=%b busy=%b want 1/0", a_done, a_busy); end
        vec++; if (a_cause !== 3'd1) begin errs++; $display("FAIL halt_cause: got %0d want 1", a_cause); end
        vec++; if (a_cycle_cnt !== 32'd10) begin errs++; $display("FAIL halt_cycles: got %0d want 10", a_cycle_cnt); end
        vec++; if (a_evt_cnt[31:0] !== 32'd10) begin errs++; $display("FAIL halt_evt0: got %0d want 10", a_evt_cnt[31:0]); end
        vec++; if (a_evt_cnt[63:32] !== 32'd0) begin errs++; $display("FAIL halt_evt1: got %0d want 0", a_evt_cnt[63:32]); end
        vec++; if (a_core_rst !== 1'b0 || a_core_en !== 1'b0) begin errs++; $display("FAIL done_core: got rst=%b en=%b want 0/0", a_core_rst, a_core_en); end
        // Requests and events in DONE must leave the frozen result alone.
        a_stop_req = 1;
        a_evt = 2'b11;
        repeat (3) tick();
        a_stop_req = 0;
        a_evt = 2'b00;
        vec++; if (a_cause !== 3'd1 || a_cycle_cnt !== 32'd10 || a_evt_cnt[31:0] !== 32'd10) begin errs++; $display("FAIL done_frozen: got cause=%0d cnt=%0d evt0=%0d want 1/10/10", a_cause, a_cycle_cnt, a_evt_cnt[31:0]); end
    endtask

    task automatic test_start_in_done();
        int n;
        a_start = 1;
        a_stop_req = 1;
        a_halt_det = 1;
        tick();
        a_start = 0;
        a_stop_req = 0;
        a_halt_det = 0;
        vec++; if (a_busy !== 1'b1 || a_done !== 1'b0 || a_core_rst !== 1'b1) begin errs++; $display("FAIL restart_state: got busy=%b done=%b rst=%b want 1/0/1", a_busy, a_done, a_core_rst); end
        vec++; if (a_cause !== 3'd0 || a_cycle_cnt !== 32'd0 || a_evt_cnt !== 64'd0) begin errs++; $display("FAIL restart_clear: got cause=%0d cnt=%0d evt=%0h want 0/0/0", a_cause, a_cycle_cnt, a_evt_cnt); end
        n = 0;
        while (a_core_rst && n < 20) begin
            n++;
            tick();
        end
        a_stop_req = 1;
        tick();
        a_stop_req = 0;
        vec++; if (a_cause !== 3'd2 || a_cycle_cnt !== 32'd1) begin errs++; $display("FAIL first_cycle_stop: got cause=%0d cnt=%0d want 2/1", a_cause, a_cycle_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        int t;
        a_start_run(n);
        a_evt = 2'b01;
        t = 0;
        while (!a_done && t < 100) begin
            a_start = (t == 10);
            tick();
            t++;
        end
        a_start = 0;
        a_evt = 2'b00;
        vec++; if (t !== 50) begin errs++; $display("FAIL timeout_run_len: got %0d want 50", t); end
        vec++; if (a_cause !== 3'd3) begin errs++; $display("FAIL timeout_cause: got %0d want 3", a_cause); end
        vec++; if (a_cycle_cnt !== 32'd50 || a_evt_cnt[31:0] !== 32'd50) begin errs++; $display("FAIL timeout_counts: got %0d/%0d want 50/50", a_cycle_cnt, a_evt_cnt[31:0]); end
    endtask

    task automatic test_priority();
        int n;
        a_start_run(n);
        repeat (2) tick();
        a_halt_det = 1;
        a_stop_req = 1;
        tick();
        a_halt_det = 0;
        a_stop_req = 0;
        vec++; if (a_cause !== 3'd1 || a_cycle_cnt !== 32'd3) begin errs++; $display("FAIL halt_over_stop: got cause=%0d cnt=%0d want 1/3", a_cause, a_cycle_cnt); end
        a_start_run(n);
        a_evt = 2'b10;
        repeat (4) tick();
        a_stop_req = 1;
        tick();
        a_stop_req = 0;
        a_evt = 2'b00;
        vec++; if (a_cause !== 3'd2 || a_cycle_cnt !== 32'd5) begin errs++; $display("FAIL stop_req: got cause=%0d cnt=%0d want 2/5", a_cause, a_cycle_cnt); end
        vec++; if (a_evt_cnt[63:32] !== 32'd5 || a_evt_cnt[31:0] !== 32'd0) begin errs++; $display("FAIL stop_evt: got %0d/%0d want 5/0", a_evt_cnt[63:32], a_evt_cnt[31:0]); end
    endtask

    task automatic test_saturate();
        int n;
        b_start_run(n);
        vec++; if (n !== 2 || b_core_en !== 1'b1) begin errs++; $display("FAIL b_hold: got %0d cycles en=%b want 2/1", n, b_core_en); end
        b_evt = 2'b10;
        repeat (20) tick();
        b_stop_req = 1;
        tick();
        b_stop_req = 0;
        b_evt = 2'b00;
        vec++; if (b_cause !== 3'd2 || b_done !== 1'b1) begin errs++; $display("FAIL b_stop: got cause=%0d done=%b want 2/1", b_cause, b_done); end
        vec++; if (b_cycle_cnt !== 4'd15) begin errs++; $display("FAIL sat_cycles: got %0d want 15", b_cycle_cnt); end
        vec++; if (b_evt_cnt[7:4] !== 4'd15 || b_evt_cnt[3:0] !== 4'd0) begin errs++; $display("FAIL sat_evt: got %0d/%0d want 15/0", b_evt_cnt[7:4], b_evt_cnt[3:0]); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        a_start_run(n);
        a_evt = 2'b11;
        repeat (5) tick();
        reset = 0;
        #2;
        vec++; if (a_core_rst !== 1'b1 || a_busy !== 1'b0 || a_core_en !== 1'b0) begin errs++; $display("FAIL async_reset: got rst=%b busy=%b en=%b want 1/0/0", a_core_rst, a_busy, a_core_en); end
        vec++; if (a_cycle_cnt !== 32'd0 || a_evt_cnt !== 64'd0) begin errs++; $display("FAIL reset_clears: got %0d/%0h want 0/0", a_cycle_cnt, a_evt_cnt); end
        tick();
        reset = 1;
        a_evt = 2'b00;
        tick();
        vec++; if (a_core_rst !== 1'b1 || a_done !== 1'b0 || a_cause !== 3'd0) begin errs++; $display("FAIL idle_after_mid_reset: got rst=%b done=%b cause=%0d want 1/0/0", a_core_rst, a_done, a_cause); end
        a_start_run(n);
        vec++; if (n !== 4 || a_cycle_cnt !== 32'd0) begin errs++; $display("FAIL rerun: got hold=%0d cnt=%0d want 4/0", n, a_cycle_cnt); end
        repeat (3) tick();
        a_stop_req = 1;
        tick();
        a_stop_req = 0;
        vec++; if (a_cycle_cnt !== 32'd4 || a_cause !== 3'd2) begin errs++; $display("FAIL rerun_stop: got cnt=%0d cause=%0d want 4/2", a_cycle_cnt, a_cause); end
    endtask

`ifdef RUN_CTRL_HANG_DETECT_EN
    task automatic test_hang();
        int n;
        int t;
        a_start_run(n);
        a_evt = 2'b10;
        t = 0;
        while (!a_done && t < 30) begin
            tick();
            t++;
        end
        a_evt = 2'b00;
        vec++; if (a_cause !== 3'd4 || t !== 8) begin errs++; $display("FAIL hang: got cause=%0d after %0d cycles want 4/8", a_cause, t); end
        vec++; if (a_cycle_cnt !== 32'd8) begin errs++; $display("FAIL hang_cycles: got %0d want 8", a_cycle_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_hold();
        test_halt();
        test_start_in_done();
        test_timeout();
        test_priority();
        test_saturate();
        test_reset_mid_run();
`ifdef RUN_CTRL_HANG_DETECT_EN
        test_hang();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
